// File: rtl/ser_frame_tx.sv
// ser_frame_tx -- serial frame transmitter feeding a serial receive controller.
//
// Sends one frame per accepted request, MSB-first:
//   start bit (0), port field (PORT_W), length field (LEN_W), len data bits.
// The line idles high. Everything advances only on clkEn cycles, so the bit
// rate matches the receiver's.
//
// Optional macro SER_TX_GAP_EN: adds a GAP state after the last bit. It holds
// the line high for GAP_CYCLES enabled cycles before returning to IDLE.
// GAP_CYCLES=0 behaves as if the macro were undefined.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   clkEn    in   bit-rate enable
//   start    in   request strobe, sampled only in IDLE with clkEn=1
//   port_in  in   [PORT_W-1:0] destination port
//   len_in   in   [LEN_W-1:0]  number of data bits, 0..DATA_W
//   data_in  in   [DATA_W-1:0] payload, data_in[len_in-1] sent first
//   ser_out  out  serial line
//   ready    out  high in IDLE only
//   busy     out  high from the start bit through the last bit (and GAP)
//   done     out  one-clk pulse at frame end
module ser_frame_tx #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 15
`ifdef SER_TX_GAP_EN
  , parameter logic [3:0] GAP_CYCLES = 4'd2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [PORT_W-1:0] port_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  localparam int HDR_W = PORT_W + LEN_W;
  localparam int CNT_B = (PORT_W > LEN_W) ? PORT_W : LEN_W;
`ifdef SER_TX_GAP_EN
  localparam int CNT_W = (CNT_B > 4) ? CNT_B : 4;
`else
  localparam int CNT_W = CNT_B;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PORT  = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
`ifdef SER_TX_GAP_EN
  localparam logic [2:0] S_GAP   = 3'd5;
`endif

  logic [2:0]        r_state;
  logic [HDR_W-1:0]  r_hdr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_done;
  logic              w_last;
  logic              w_ser;

  // Enabled cycle carrying the frame's final bit (last LEN bit when len=0).
  assign w_last = clkEn && (r_cnt == '0) &&
                  ((r_state == S_DATA) || ((r_state == S_LEN) && (r_len == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hdr   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      // done is a single clk pulse, cleared even while clkEn is low.
      r_done <= 1'b0;
      if (clkEn) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_hdr   <= {port_in, len_in};
              r_len   <= len_in;
              // Left-justify the payload so its MSB is data_in[len_in-1].
              r_data  <= data_in << (DATA_W - int'(len_in));
              r_state <= S_START;
            end
          end
          S_START: begin
            r_cnt   <= CNT_W'(PORT_W - 1);
            r_state <= S_PORT;
          end
          S_PORT: begin
            r_hdr <= r_hdr << 1;
            if (r_cnt == '0) begin
              r_cnt   <= CNT_W'(LEN_W - 1);
              r_state <= S_LEN;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_LEN: begin
            r_hdr <= r_hdr << 1;
            if (r_cnt == '0) begin
              if (r_len != '0) begin
                r_cnt   <= CNT_W'(r_len) - 1'b1;
                r_state <= S_DATA;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DATA: begin
            r_data <= r_data << 1;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end
`ifdef SER_TX_GAP_EN
          S_GAP: begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase

        // Frame end overrides the per-state next-state above.
        if (w_last) begin
`ifdef SER_TX_GAP_EN
          if (GAP_CYCLES != 4'd0) begin
            r_cnt   <= CNT_W'(GAP_CYCLES) - 1'b1;
            r_state <= S_GAP;
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
`else
          r_state <= S_IDLE;
          r_done  <= 1'b1;
`endif
        end
      end
    end
  end

  // Line level depends only on registered state, never directly on inputs.
  always_comb begin
    w_ser = 1'b1;
    case (r_state)
      S_START:        w_ser = 1'b0;
      S_PORT, S_LEN:  w_ser = r_hdr[HDR_W-1];
      S_DATA:         w_ser = r_data[DATA_W-1];
      default:        w_ser = 1'b1;
    endcase
  end

  assign ser_out = w_ser;
  assign ready   = (r_state == S_IDLE);
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule
